// File: rtl/adau_pkg.sv
// Shared types and constants for the ADAU codec configuration path.
// Each word is chip address/RW, a 16-bit register address, and 8 bits of data.
package adau_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        DUMMY,
        INIT,
        POST_WAIT,
        RUN
    } adau_state_t;

    localparam logic [31:0] ADAU_DUMMY_WORD = 32'h0040_0000;

    localparam int CHIP_MSB = 31;
    localparam int CHIP_LSB = 24;
    localparam int REG_MSB  = 23;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef struct packed {
        logic        wait_after;
        logic [31:0] word;
    } rom_entry_t;

    function automatic logic [31:0] adau_wr(input logic [15:0] reg_addr, input logic [7:0] val);
        logic [31:0] w;
        w = '0;
        w[CHIP_MSB:CHIP_LSB] = 8'h00;
        w[REG_MSB:REG_LSB]   = reg_addr;
        w[DATA_MSB:DATA_LSB] = val;
        return w;
    endfunction

endpackage

// File: rtl/adau_init_rom.sv
// Board-specific codec init table: combinational index -> {wait_after, word}.
// Entry 1 enables the PLL, so the sequencer pauses after it for lock.
module adau_init_rom
    import adau_pkg::*;
(
    input  logic [3:0] idx,
    output rom_entry_t entry
);

    always_comb begin
        entry = '0;
        case (idx)
            4'd0:    entry = {1'b0, adau_wr(16'h4000, 8'h0E)};
            4'd1:    entry = {1'b1, adau_wr(16'h4002, 8'h01)};
            4'd2:    entry = {1'b0, adau_wr(16'h4000, 8'h0F)};
            4'd3:    entry = {1'b0, adau_wr(16'h4015, 8'h01)};
            4'd4:    entry = {1'b0, adau_wr(16'h4016, 8'h00)};
            4'd5:    entry = {1'b0, adau_wr(16'h4017, 8'h00)};
            4'd6:    entry = {1'b0, adau_wr(16'h4019, 8'h13)};
            4'd7:    entry = {1'b0, adau_wr(16'h401C, 8'h21)};
            4'd8:    entry = {1'b0, adau_wr(16'h401E, 8'h41)};
            4'd9:    entry = {1'b0, adau_wr(16'h4023, 8'hE7)};
            4'd10:   entry = {1'b0, adau_wr(16'h4024, 8'hE7)};
            4'd11:   entry = {1'b0, adau_wr(16'h4029, 8'h03)};
            4'd12:   entry = {1'b0, adau_wr(16'h402A, 8'h03)};
            4'd13:   entry = {1'b0, adau_wr(16'h40F2, 8'h01)};
            4'd14:   entry = {1'b0, adau_wr(16'h40F9, 8'h7F)};
            default: entry = {1'b0, adau_wr(16'h40FA, 8'h03)};
        endcase
    end

endmodule

// File: rtl/adau_config_sequencer.sv
// Powers up the codec, enters SPI mode, streams the init ROM, then grants the SPI master to one runtime requester.
// One outstanding word at a time; spi_valid/spi_data hold until spi_ready, and usr_ready is low while a word is pending.
module adau_config_sequencer
    import adau_pkg::*;
#(
    parameter int INIT_WAIT_CYCLES = 1200000,
    parameter int DUMMY_WRITES     = 3,
    parameter int NUM_INIT_WORDS   = 16,
    parameter int POST_WAIT_CYCLES = 240000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] spi_data,
    output logic        spi_valid,
    input  logic        spi_ready,
    input  logic [31:0] usr_data,
    input  logic        usr_valid,
    output logic        usr_ready,
    output logic        init_done,
    output logic        busy
);

    localparam int MAX_WAIT   = (INIT_WAIT_CYCLES > POST_WAIT_CYCLES) ? INIT_WAIT_CYCLES : POST_WAIT_CYCLES;
    localparam int CNT_W      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int IDX_W      = (NUM_INIT_WORDS > 1) ? $clog2(NUM_INIT_WORDS) : 1;
    localparam int DCNT_W     = (DUMMY_WRITES > 0) ? $clog2(DUMMY_WRITES + 1) : 1;
    localparam int INIT_LAST  = (INIT_WAIT_CYCLES > 0) ? INIT_WAIT_CYCLES - 1 : 0;
    localparam int POST_LAST  = (POST_WAIT_CYCLES > 0) ? POST_WAIT_CYCLES - 1 : 0;
    localparam int DUMMY_LAST = (DUMMY_WRITES > 0) ? DUMMY_WRITES - 1 : 0;
    localparam int LAST_IDX   = NUM_INIT_WORDS - 1;

    adau_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    rom_entry_t        rom_entry;
    logic              xfer;
    logic              run_idle;

    adau_init_rom u_rom (
        .idx   (4'(idx_q)),
        .entry (rom_entry)
    );

    // ROM words are driven straight from the table so the next entry is ready the cycle after acceptance.
    assign spi_data  = (state_q == INIT) ? rom_entry.word : data_q;
    assign spi_valid = valid_q;
    assign init_done = done_q;
    assign xfer      = valid_q && spi_ready;
    assign run_idle  = (state_q == RUN) && !valid_q;
    assign usr_ready = run_idle;
    assign busy      = !run_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= POWERUP;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = done_q;
        case (state_q)
            POWERUP: begin
                if (cnt_q == CNT_W'(INIT_LAST)) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    if (DUMMY_WRITES == 0) begin
                        state_d = INIT;
                    end else begin
                        state_d = DUMMY;
                        data_d  = ADAU_DUMMY_WORD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DUMMY: begin
                if (xfer) begin
                    if (dcnt_q == DCNT_W'(DUMMY_LAST)) begin
                        dcnt_d  = '0;
                        state_d = INIT;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end
            INIT: begin
                // The last entry ends init even if flagged, there is nothing left to wait for.
                if (xfer) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = RUN;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (rom_entry.wait_after) begin
                        state_d = POST_WAIT;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            POST_WAIT: begin
                if (cnt_q == CNT_W'(POST_LAST)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = INIT;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (xfer) begin
                    valid_d = 1'b0;
                end else if (usr_valid && run_idle) begin
                    valid_d = 1'b1;
                    data_d  = usr_data;
                end
            end
            default: state_d = POWERUP;
        endcase
    end

endmodule

// File: tb/tb_adau_config_sequencer.sv
// Directed bench for the ADAU config sequencer: cycle vector table plus handshake, backpressure and reset sequences.
module tb_adau_config_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] spi_data;
    logic        spi_valid;
    logic        spi_ready = 1'b0;
    logic [31:0] usr_data = '0;
    logic        usr_valid = 1'b0;
    logic        usr_ready;
    logic        init_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adau_config_sequencer #(
        .INIT_WAIT_CYCLES (10),
        .DUMMY_WRITES     (3),
        .NUM_INIT_WORDS   (4),
        .POST_WAIT_CYCLES (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_data  (spi_data),
        .spi_valid (spi_valid),
        .spi_ready (spi_ready),
        .usr_data  (usr_data),
        .usr_valid (usr_valid),
        .usr_ready (usr_ready),
        .init_done (init_done),
        .busy      (busy)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        uv;
        logic [31:0] ud;
        int          n;
        logic        e_v;
        logic        chk_d;
        logic [31:0] e_d;
        logic        e_urdy;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vecs[15];

    localparam logic [31:0] DW   = 32'h0040_0000;
    localparam logic [31:0] ROM0 = 32'h0040_000E;
    localparam logic [31:0] ROM1 = 32'h0040_0201;
    localparam logic [31:0] ROM2 = 32'h0040_000F;
    localparam logic [31:0] ROM3 = 32'h0040_1501;
    localparam logic [31:0] UW   = 32'h0040_1C2A;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            reset     = vecs[i].rst;
            spi_ready = vecs[i].rdy;
            usr_valid = vecs[i].uv;
            usr_data  = vecs[i].ud;
            for (int r = 0; r < vecs[i].n; r++) begin
                step();
                chk($sformatf("v%0d.%0d_valid", i, r), 32'(spi_valid), 32'(vecs[i].e_v));
                if (vecs[i].chk_d)
                    chk($sformatf("v%0d.%0d_data", i, r), spi_data, vecs[i].e_d);
                chk($sformatf("v%0d.%0d_usr_ready", i, r), 32'(usr_ready), 32'(vecs[i].e_urdy));
                chk($sformatf("v%0d.%0d_init_done", i, r), 32'(init_done), 32'(vecs[i].e_done));
                chk($sformatf("v%0d.%0d_busy", i, r), 32'(busy), 32'(vecs[i].e_busy));
            end
        end
    endtask

    logic        pre_v, pre_r, pre_uhs, pre_done, a_done;
    logic [31:0] pre_d;
    logic [31:0] acc_q[$];
    logic [31:0] exp_acc[8];
    int          stab_err, early_rdy, bp_err, usr_hs;

    initial begin
        //            rst  rdy  uv   ud             n   e_v  chk_d e_d   urdy done busy
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,          1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,          1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,          9, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1, 1'b1, 1'b1, DW,    1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,          2, 1'b1, 1'b1, DW,    1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1, 1'b1, 1'b1, ROM0,  1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1, 1'b1, 1'b1, ROM1,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,          5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1, 1'b1, 1'b1, ROM2,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1, 1'b1, 1'b1, ROM3,  1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,          1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0040_2301,  1, 1'b1, 1'b1, 32'h0040_2301, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h0040_2302,  1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h0040_2302,  1, 1'b1, 1'b1, 32'h0040_2302, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,          1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0};

        exp_acc = '{DW, DW, DW, ROM0, ROM1, ROM2, ROM3, UW};

        // Full init with an always-ready master, post-wait gap, back-to-back runtime words.
        run_vectors(0, 14);

        // Slow master (ready 1 cycle in 8) with a runtime request held from reset.
        reset = 1'b1; usr_valid = 1'b1; usr_data = UW; spi_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        a_done = 1'b0; stab_err = 0; early_rdy = 0; bp_err = 0; usr_hs = 0;
        for (int cyc = 0; cyc < 600 && !a_done; cyc++) begin
            spi_ready = (cyc % 8 == 7);
            pre_v = spi_valid; pre_r = spi_ready; pre_d = spi_data;
            pre_uhs = usr_valid && usr_ready; pre_done = init_done;
            if (pre_v && pre_r) acc_q.push_back(pre_d);
            step();
            if (pre_v && !pre_r && (!spi_valid || spi_data !== pre_d)) stab_err++;
            if (!init_done && usr_ready) early_rdy++;
            if (spi_valid && usr_ready) bp_err++;
            if (pre_v && pre_r && acc_q.size() == 7) begin
                chk("init_done_before_last", 32'(pre_done), 32'd0);
                chk("init_done_after_last", 32'(init_done), 32'd1);
            end
            if (pre_uhs) begin
                usr_hs++;
                usr_valid = 1'b0;
                chk("usr_word_valid", 32'(spi_valid), 32'd1);
                chk("usr_word_data", spi_data, UW);
            end
            if (pre_v && pre_r && pre_d === UW) a_done = 1'b1;
        end
        chk("slow_seq_complete", 32'(a_done), 32'd1);
        chk("slow_seq_count", 32'(acc_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_q.size(); i++)
            chk($sformatf("slow_acc%0d", i), acc_q[i], exp_acc[i]);
        chk("stall_stability", 32'(stab_err), 32'd0);
        chk("usr_ready_before_init", 32'(early_rdy), 32'd0);
        chk("usr_backpressure", 32'(bp_err), 32'd0);
        chk("usr_handshakes", 32'(usr_hs), 32'd1);

        // Reset while presenting ROM[2], then a full restart including dummy writes.
        spi_ready = 1'b1;
        run_vectors(0, 8);
        chk("midinit_valid_before_reset", 32'(spi_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("midinit_reset_valid", 32'(spi_valid), 32'd0);
        chk("midinit_reset_data", spi_data, 32'h0);
        chk("midinit_reset_done", 32'(init_done), 32'd0);
        chk("midinit_reset_busy", 32'(busy), 32'd1);
        run_vectors(1, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
